acc: RTL and testbench



---
 rtl/acc.sv | 40 ++++
 tb/tb_acc.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/acc.sv
// Registered accumulator: q accumulates d on every rising clock edge,
// wrapping modulo 2^WIDTH. ovf holds the carry-out of the latest addition
// and is not sticky. Reset is synchronous and active-low.
module acc #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             ovf
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             ovf_q;
    logic             ovf_d;

    // Next sum computed one bit wider so the carry-out lands in ovf_d.
    always_comb begin
        {ovf_d, acc_d} = {1'b0, acc_q} + {1'b0, d};
    end

    // State register: reset clears both sum and carry and takes priority
    // over d; otherwise load the new sum and carry every edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    // Outputs come straight from the registers; no path from d.
    assign q   = acc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_acc.sv
// Directed bench for acc at WIDTH=4: a table of {rst, d, expected q/ovf}
// rows applied one per clock edge, then hand-written multi-cycle sequences
// covering mid-cycle reset assertion, the absence of a d-to-q path and the
// non-sticky ovf.
module tb_acc;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         ovf;

  int n_vec;
  int n_err;

  typedef struct {
    logic         rst;
    logic [W-1:0] d;
    logic [W-1:0] exp_q;
    logic         exp_ovf;
    string        name;
  } vec_t;

  vec_t vecs[$];

  acc #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q),
    .ovf (ovf)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void add_vec(input logic r, input logic [W-1:0] dv,
                                  input logic [W-1:0] eq, input logic eo,
                                  input string nm);
    vec_t v;
    v.rst     = r;
    v.d       = dv;
    v.exp_q   = eq;
    v.exp_ovf = eo;
    v.name    = nm;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [W-1:0] eq, input logic eo);
    n_vec++;
    if (q !== eq || ovf !== eo) begin
      n_err++;
      $display("FAIL %s: got q=%h ovf=%b, expected q=%h ovf=%b", nm, q, ovf, eq, eo);
    end
  endtask

  // Drive inputs at the falling edge, clock once, sample at the next falling edge.
  task automatic step(input logic r, input logic [W-1:0] dv);
    rst = r;
    d   = dv;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    d     = '0;

    // Reset held for 5 edges with d=0xA
    for (int i = 0; i < 5; i++) add_vec(1'b0, 4'hA, 4'h0, 1'b0, "reset_hold");
    // Basic accumulate
    add_vec(1'b1, 4'h1, 4'h1, 1'b0, "acc_1");
    add_vec(1'b1, 4'h2, 4'h3, 1'b0, "acc_2");
    add_vec(1'b1, 4'h3, 4'h6, 1'b0, "acc_3");
    add_vec(1'b1, 4'h4, 4'hA, 1'b0, "acc_4");
    // Reach 0xF, then wrap
    add_vec(1'b1, 4'h5, 4'hF, 1'b0, "to_f");
    add_vec(1'b1, 4'h1, 4'h0, 1'b1, "wrap_f_plus_1");
    add_vec(1'b1, 4'h0, 4'h0, 1'b0, "wrap_then_zero");
    // Hold at 0x7
    add_vec(1'b1, 4'h7, 4'h7, 1'b0, "to_7");
    for (int i = 0; i < 3; i++) add_vec(1'b1, 4'h0, 4'h7, 1'b0, "hold_7");
    // Back to zero via reset, then maximum addend
    add_vec(1'b0, 4'h3, 4'h0, 1'b0, "reset_again");
    add_vec(1'b1, 4'hF, 4'hF, 1'b0, "max_1");
    add_vec(1'b1, 4'hF, 4'hE, 1'b1, "max_2");
    add_vec(1'b1, 4'hF, 4'hD, 1'b1, "max_3");
    // 0xE + 0x3 -> 0x1 with carry
    add_vec(1'b1, 4'h1, 4'hE, 1'b0, "to_e");
    add_vec(1'b1, 4'h3, 4'h1, 1'b1, "e_plus_3");
    // Mid-run reset discards its addend
    add_vec(1'b1, 4'h8, 4'h9, 1'b0, "to_9");
    add_vec(1'b0, 4'h5, 4'h0, 1'b0, "midrun_reset");
    add_vec(1'b1, 4'h5, 4'h5, 1'b0, "after_reset");
    // Reset clears a pending carry: 5 + F = 0x14
    add_vec(1'b1, 4'hF, 4'h4, 1'b1, "carry_set");
    add_vec(1'b0, 4'h0, 4'h0, 1'b0, "reset_clears_ovf");

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].d);
      check(vecs[i].name, vecs[i].exp_q, vecs[i].exp_ovf);
    end

    // Sequence: reset asserted between edges does nothing until the edge,
    // and changing d mid-cycle does not reach q.
    step(1'b1, 4'h6);
    check("seq_load_6", 4'h6, 1'b0);
    rst = 1'b0;
    d   = 4'h9;
    #2;
    check("seq_no_early_reset", 4'h6, 1'b0);
    d   = 4'hC;
    #1;
    check("seq_no_comb_path", 4'h6, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("seq_reset_at_edge", 4'h0, 1'b0);

    // Sequence: release before an edge gives 0 + d, then ovf is not sticky.
    step(1'b1, 4'hF);
    check("seq_release_0_plus_d", 4'hF, 1'b0);
    step(1'b1, 4'h2);
    check("seq_carry", 4'h1, 1'b1);
    step(1'b1, 4'h3);
    check("seq_ovf_not_sticky", 4'h4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
